hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the saturating performance counters.
REQ-002 Parameter TIMEOUT, default 255, memory-wait cycle limit before the error flag is raised.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rs1_D, rs2_D  in  5 each  source register indices of the instruction in ID.
REQ-006 rs1_E, rs2_E  in  5 each  source register indices of the instruction in EX.
REQ-007 Rd_E, MemRead_E  in  5/1  EX-stage destination register and load flag.
REQ-008 Rd_M, regWrite_M  in  5/1  MEM-stage destination register and write enable.
REQ-009 Rd_W, regWrite_W  in  5/1  WB-stage destination register and write enable.
REQ-010 branch_taken_E  in  1  taken branch, jal or jalr resolved in EX.
REQ-011 dmem_req_M, dmem_ready_M  in  1/1  data-memory request and ready handshake.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  stage-register enables.
REQ-013 if_id_flush, id_ex_flush  out  1 each  insert a bubble (zero control) on the next clock.
REQ-014 fwdA_E, fwdB_E  out  2 each  ALU operand select: 00 register file, 10 from MEM, 01 from WB.
REQ-015 stall_cycles, flush_events  out  CNT_W each  performance counters.
REQ-016 mem_timeout  out  1  sticky memory-wait timeout error.

Function
REQ-017 Definitions:
- freeze = dmem_req_M & ~dmem_ready_M.
- flush = branch_taken_E & ~freeze.
- load_use = MemRead_E & (Rd_E!=0) & (Rd_E==rs1_D | Rd_E==rs2_D) & ~freeze & ~branch_taken_E.
REQ-018 Priority is freeze > flush > load_use > normal; all control outputs are combinational from the current inputs.
REQ-019 Normal operation: all four enables are 1 and both flushes are 0.
REQ-020 Freeze: all four enables are 0 and both flushes are 0; branch_taken_E is held and acted on once the freeze ends.
REQ-021 Flush: all enables are 1 (pc loads the target), if_id_flush=1 and id_ex_flush=1, giving two bubbles.
REQ-022 Load-use: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, if_id_flush=0; the stall lasts exactly one cycle because the load then leaves EX.
REQ-023 fwdA_E selection:
- 10 if regWrite_M & Rd_M!=0 & Rd_M==rs1_E;
- else 01 if regWrite_W & Rd_W!=0 & Rd_W==rs1_E;
- else 00.
- fwdB_E is identical using rs2_E.
- MEM has priority over WB.
- Forwarding is independent of freeze.
REQ-024 The FSM has two states, RUN and MEM_WAIT, plus a wait counter wait_cnt (width ceil(log2(TIMEOUT+1))).
REQ-025 RUN transitions:
- freeze=1: go to MEM_WAIT and set wait_cnt=1.
- otherwise stay in RUN.
REQ-026 MEM_WAIT transitions:
- freeze=1: stay, and increment wait_cnt, saturating at TIMEOUT.
- freeze=0: go to RUN and clear wait_cnt.
REQ-027 mem_timeout is set on the clock edge where state=MEM_WAIT, wait_cnt==TIMEOUT and freeze=1; it then remains 1 until rst, and the pipeline stays frozen.
REQ-028 stall_cycles increments by 1 on every clock where freeze or load_use is 1, saturating at all-ones.
REQ-029 flush_events increments by 1 on every clock where flush is 1, saturating at all-ones.
REQ-030 When dmem_ready_M arrives together with branch_taken_E, the flush takes effect in that same cycle.

Reset
REQ-031 While rst=1:
- all enables = 0, both flushes = 0, fwdA_E = fwdB_E = 00;
- state = RUN, wait_cnt = 0;
- stall_cycles = 0, flush_events = 0, mem_timeout = 0.
REQ-032 Reset asserted during MEM_WAIT or after a timeout returns the block to RUN on the next edge with all counters and flags cleared.

Verification
REQ-033 Load-use: MemRead_E=1, Rd_E=5, rs2_D=5 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles goes 0->1; next cycle with MemRead_E=0 -> normal outputs.
REQ-034 Branch beats load-use: branch_taken_E=1 together with a load-use match -> if_id_flush=id_ex_flush=1, pc_en=1, flush_events=1, stall_cycles unchanged.
REQ-035 Memory wait: dmem_req_M=1, dmem_ready_M=0 for 3 cycles, then ready=1 -> enables 0 for 3 cycles, state MEM_WAIT, stall_cycles=3; then enables 1 and state RUN.
REQ-036 Timeout with TIMEOUT=4: ready held low for 6 cycles -> mem_timeout=1 from the 5th edge onward, still 1 after ready returns, cleared only by rst.
REQ-037 Forwarding: Rd_M=Rd_W=7, both write enables 1, rs1_E=7 -> fwdA_E=10; with regWrite_M=0 -> 01; with Rd_M=Rd_W=0 -> 00.
REQ-038 Saturation with CNT_W=4: 20 consecutive freeze cycles -> stall_cycles=15 and held there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forward decisions for a 5-stage core,
// data-memory wait tracking with sticky timeout, and saturating perf counters.
module hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic [4:0]       rs1_E,
   input  logic [4:0]       rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic             MemRead_E,
   input  logic [4:0]       Rd_M,
   input  logic             regWrite_M,
   input  logic [4:0]       Rd_W,
   input  logic             regWrite_W,
   input  logic             branch_taken_E,
   input  logic             dmem_req_M,
   input  logic             dmem_ready_M,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events,
   output logic             mem_timeout
);

   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t            r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_mem_timeout;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic [CNT_W-1:0]  r_flush_events;

   logic w_freeze;
   logic w_flush;
   logic w_load_use;

   // A timed-out memory access keeps the pipeline frozen until reset.
   assign w_freeze   = (dmem_req_M & ~dmem_ready_M) | r_mem_timeout;
   assign w_flush    = branch_taken_E & ~w_freeze;
   assign w_load_use = MemRead_E & (Rd_E != 5'd0) &
                       ((Rd_E == rs1_D) | (Rd_E == rs2_D)) &
                       ~w_freeze & ~branch_taken_E;

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (!rst) begin
         if (w_freeze) begin
            pc_en = 1'b0;
         end else if (w_flush) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (w_load_use) begin
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            id_ex_flush = 1'b1;
         end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
         end
      end
   end

   // Operand 0 is ALU A (rs1_E), operand 1 is ALU B (rs2_E); MEM beats WB.
   logic [4:0] w_rs_E [2];
   logic [1:0] w_fwd  [2];
   assign w_rs_E[0] = rs1_E;
   assign w_rs_E[1] = rs2_E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         always_comb begin
            w_fwd[gi] = 2'b00;
            if (!rst) begin
               if (regWrite_M && (Rd_M != 5'd0) && (Rd_M == w_rs_E[gi]))
                  w_fwd[gi] = 2'b10;
               else if (regWrite_W && (Rd_W != 5'd0) && (Rd_W == w_rs_E[gi]))
                  w_fwd[gi] = 2'b01;
            end
         end
      end
   endgenerate

   assign fwdA_E = w_fwd[0];
   assign fwdB_E = w_fwd[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (w_freeze) begin
                  r_state    <= MEM_WAIT;
                  r_wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (w_freeze) begin
                  if (r_wait_cnt == WAIT_MAX)
                     r_mem_timeout <= 1'b1;
                  else
                     r_wait_cnt <= r_wait_cnt + 1'b1;
               end else begin
                  r_state    <= RUN;
                  r_wait_cnt <= '0;
               end
            end
            default: begin
               r_state    <= RUN;
               r_wait_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if ((w_freeze || w_load_use) && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
         if (w_flush && (r_flush_events != {CNT_W{1'b1}}))
            r_flush_events <= r_flush_events + 1'b1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
   assign mem_timeout  = r_mem_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of combinational vectors plus
// hand-written multi-cycle sequences (load-use, branch, memory wait, timeout, saturation).
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, Rd_E, Rd_M, Rd_W;
   logic       MemRead_E, regWrite_M, regWrite_W, branch_taken_E;
   logic       dmem_req_M, dmem_ready_M;
   logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
   logic [1:0] fwdA_E, fwdB_E;
   logic [CNT_W-1:0] stall_cycles, flush_events;
   logic       mem_timeout;

   hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
      .Rd_E(Rd_E), .MemRead_E(MemRead_E),
      .Rd_M(Rd_M), .regWrite_M(regWrite_M),
      .Rd_W(Rd_W), .regWrite_W(regWrite_W),
      .branch_taken_E(branch_taken_E),
      .dmem_req_M(dmem_req_M), .dmem_ready_M(dmem_ready_M),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
      .stall_cycles(stall_cycles), .flush_events(flush_events),
      .mem_timeout(mem_timeout)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Enables packed {pc, if_id, id_ex, ex_mem}; flushes packed {if_id, id_ex}.
   function automatic logic [3:0] en_now();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en};
   endfunction
   function automatic logic [1:0] fl_now();
      return {if_id_flush, id_ex_flush};
   endfunction

   task automatic idle();
      rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
      MemRead_E = 0; regWrite_M = 0; regWrite_W = 0; branch_taken_E = 0;
      dmem_req_M = 0; dmem_ready_M = 0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; idle(); tick(); rst = 1'b0;
   endtask

   typedef struct {
      logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, Rd_E, Rd_M, Rd_W;
      logic       mr, wm, ww, br, req, rdy;
      logic [3:0] en;
      logic [1:0] fl, fa, fb;
   } vec_t;

   vec_t vt[13];

   initial begin
      //        rs1D rs2D rs1E rs2E RdE RdM RdW mr wm ww br rq rd  en       fl     fa     fb
      vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00};
      vt[1]  = '{3, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 4'b0011, 2'b01, 2'b00, 2'b00};
      vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00};
      vt[3]  = '{3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00};
      vt[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 2'b11, 2'b00, 2'b00};
      vt[5]  = '{0, 6, 0, 0, 6, 0, 0, 1, 0, 0, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 2'b00};
      vt[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4'b1111, 2'b11, 2'b00, 2'b00};
      vt[7]  = '{0, 0, 7, 7, 0, 7, 7, 0, 1, 1, 0, 0, 0, 4'b1111, 2'b00, 2'b10, 2'b10};
      vt[8]  = '{0, 0, 7, 7, 0, 7, 7, 0, 0, 1, 0, 0, 0, 4'b1111, 2'b00, 2'b01, 2'b01};
      vt[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00};
      vt[10] = '{0, 0, 7, 9, 0, 9, 7, 0, 1, 1, 0, 0, 0, 4'b1111, 2'b00, 2'b01, 2'b10};
      vt[11] = '{0, 0, 4, 0, 0, 4, 0, 0, 1, 0, 0, 1, 0, 4'b0000, 2'b00, 2'b10, 2'b00};
      vt[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 2'b00, 2'b00, 2'b00};

      // Reset state, with inputs that would otherwise forward and flush.
      rst = 1'b1; idle();
      Rd_M = 7; regWrite_M = 1; rs1_E = 7; rs2_E = 7; branch_taken_E = 1;
      #1;
      chk("rst_en", 32'(en_now()), 32'h0);
      chk("rst_fl", 32'(fl_now()), 32'h0);
      chk("rst_fwd", 32'({fwdA_E, fwdB_E}), 32'h0);
      tick(); tick();
      chk("rst_stall", 32'(stall_cycles), 32'h0);
      chk("rst_flushcnt", 32'(flush_events), 32'h0);
      chk("rst_timeout", 32'(mem_timeout), 32'h0);
      rst = 1'b0; idle();

      // Table of combinational vectors, one per cycle.
      for (int i = 0; i < 13; i++) begin
         rs1_D = vt[i].rs1_D; rs2_D = vt[i].rs2_D; rs1_E = vt[i].rs1_E; rs2_E = vt[i].rs2_E;
         Rd_E = vt[i].Rd_E; Rd_M = vt[i].Rd_M; Rd_W = vt[i].Rd_W;
         MemRead_E = vt[i].mr; regWrite_M = vt[i].wm; regWrite_W = vt[i].ww;
         branch_taken_E = vt[i].br; dmem_req_M = vt[i].req; dmem_ready_M = vt[i].rdy;
         #1;
         chk($sformatf("vec%0d_en", i), 32'(en_now()), 32'(vt[i].en));
         chk($sformatf("vec%0d_fl", i), 32'(fl_now()), 32'(vt[i].fl));
         chk($sformatf("vec%0d_fwdA", i), 32'(fwdA_E), 32'(vt[i].fa));
         chk($sformatf("vec%0d_fwdB", i), 32'(fwdB_E), 32'(vt[i].fb));
         tick();
      end

      // Load-use stall for one cycle.
      do_reset();
      MemRead_E = 1; Rd_E = 5; rs2_D = 5; #1;
      chk("lu_en", 32'(en_now()), 32'b0011);
      chk("lu_fl", 32'(fl_now()), 32'b01);
      tick();
      chk("lu_stall", 32'(stall_cycles), 32'd1);
      MemRead_E = 0; #1;
      chk("lu_after_en", 32'(en_now()), 32'b1111);
      chk("lu_after_fl", 32'(fl_now()), 32'b00);
      tick();
      chk("lu_after_stall", 32'(stall_cycles), 32'd1);

      // Branch wins over load-use.
      do_reset();
      MemRead_E = 1; Rd_E = 5; rs1_D = 5; branch_taken_E = 1; #1;
      chk("br_lu_en", 32'(en_now()), 32'b1111);
      chk("br_lu_fl", 32'(fl_now()), 32'b11);
      tick();
      chk("br_lu_flushcnt", 32'(flush_events), 32'd1);
      chk("br_lu_stall", 32'(stall_cycles), 32'd0);

      // Memory wait of three cycles, then ready.
      do_reset();
      dmem_req_M = 1; dmem_ready_M = 0;
      for (int k = 0; k < 3; k++) begin
         #1; chk($sformatf("mw_en%0d", k), 32'(en_now()), 32'b0000);
         tick();
      end
      chk("mw_stall", 32'(stall_cycles), 32'd3);
      dmem_ready_M = 1; #1;
      chk("mw_ready_en", 32'(en_now()), 32'b1111);
      tick();
      chk("mw_stall_hold", 32'(stall_cycles), 32'd3);
      chk("mw_no_timeout", 32'(mem_timeout), 32'd0);

      // Timeout: set on the 5th edge, sticky until reset.
      do_reset();
      dmem_req_M = 1; dmem_ready_M = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("to_edge%0d", k), 32'(mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
      end
      dmem_ready_M = 1; tick(); tick();
      chk("to_sticky", 32'(mem_timeout), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0; idle(); #1;
      chk("to_cleared", 32'(mem_timeout), 32'd0);
      chk("to_cleared_stall", 32'(stall_cycles), 32'd0);
      chk("to_cleared_en", 32'(en_now()), 32'b1111);
      tick();
      chk("to_stays_clear", 32'(mem_timeout), 32'd0);

      // Counter saturation.
      do_reset();
      dmem_req_M = 1; dmem_ready_M = 0;
      for (int k = 0; k < 20; k++) tick();
      chk("sat_stall", 32'(stall_cycles), 32'd15);
      tick();
      chk("sat_stall_hold", 32'(stall_cycles), 32'd15);
      do_reset();
      branch_taken_E = 1;
      for (int k = 0; k < 20; k++) tick();
      chk("sat_flush", 32'(flush_events), 32'd15);
      chk("sat_flush_nostall", 32'(stall_cycles), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
